// File: rtl/gpu_instr_pkg.sv
// gpu_instr_pkg: shared constants and the instruction word-pair type for the
// GPU instruction intake path.
//   GPU_DATA_W     - width of one instruction word (A or B)
//   GPU_FIFO_DEPTH - default intake FIFO depth
//   gpu_instr_t    - packed {a, b} instruction pair
package gpu_instr_pkg;

  localparam int GPU_DATA_W     = 32;
  localparam int GPU_FIFO_DEPTH = 16;

  typedef struct packed {
    logic [GPU_DATA_W-1:0] a;
    logic [GPU_DATA_W-1:0] b;
  } gpu_instr_t;

endpackage

// File: rtl/gpu_instr_fifo.sv
// gpu_instr_fifo: generic synchronous show-ahead FIFO.
//   clk_i    - clock
//   rst_n_i  - synchronous active-low reset (pointers/count only, memory kept)
//   push_i   - write request; honoured when not full, or when full and a pop
//              happens in the same cycle
//   wdata_i  - write data
//   pop_i    - read request; ignored when empty
//   rdata_o  - head entry (mem[rd_ptr]), valid whenever empty_o is low
//   full_o   - count == DEPTH
//   empty_o  - count == 0
module gpu_instr_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  // When full, the slot being written is the one being popped this cycle,
  // so a simultaneous push is safe.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never reset; contents behind count are don't-care.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/gpu_instr_intake.sv
// gpu_instr_intake: receives {data_a, data_b} instruction pairs on rising
// edges of the PIO strobe wrreg, buffers them in a show-ahead FIFO and hands
// them to the decoder over instr_valid/instr_ready.
//   clk_clk       - clock
//   reset_reset_n - synchronous active-low reset
//   data_a/data_b - instruction words, sampled on the wrreg rising edge cycle
//   wrreg         - write strobe (level; one request per rising edge)
//   wrfull        - FIFO full, software polls before writing
//   instr_a/b     - head entry
//   instr_valid   - head entry valid
//   instr_ready   - decoder accepts head entry
//   drop_cnt      - saturating dropped-write count; only when
//                   GPU_INSTR_DROP_CNT_EN is defined
module gpu_instr_intake
  import gpu_instr_pkg::*;
#(
  parameter int DEPTH  = GPU_FIFO_DEPTH,
  parameter int DATA_W = GPU_DATA_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [DATA_W-1:0] data_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              wrreg,
  output logic              wrfull,
  output logic [DATA_W-1:0] instr_a,
  output logic [DATA_W-1:0] instr_b,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef GPU_INSTR_DROP_CNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  logic              wrreg_q;
  logic              push_req, pop, accept;
  logic              empty;
  logic [2*DATA_W-1:0] rdata;

  // wrreg_q clears on reset, so a strobe already high at release counts
  // as a fresh edge.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) wrreg_q <= 1'b0;
    else                wrreg_q <= wrreg;
  end

  assign push_req = wrreg & ~wrreg_q;
  assign pop      = instr_valid & instr_ready;
  assign accept   = push_req & (~wrfull | pop);

  gpu_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*DATA_W)
  ) u_fifo (
    .clk_i   (clk_clk),
    .rst_n_i (reset_reset_n),
    .push_i  (accept),
    .wdata_i ({data_a, data_b}),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (wrfull),
    .empty_o (empty)
  );

  assign instr_valid = ~empty;
  assign instr_a     = rdata[2*DATA_W-1:DATA_W];
  assign instr_b     = rdata[DATA_W-1:0];

`ifdef GPU_INSTR_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (push_req && !accept && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) drop_q <= '0;
    else                drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: doc/gpu_instr_intake.md
# gpu_instr_intake

Instruction intake for the graphics processor: receives 64-bit instructions (`data_a`/`data_b` word pair) written by the Nios-side PIO strobe `wrreg`, and buffers them in a synchronous FIFO. It reports back-pressure on `wrfull` and hands instructions to the GPU decoder over a valid/ready handshake. It is the receiving end of the `data_a`/`data_b`/`wrreg`/`wrfull` path exported by the processor system.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `DATA_W`, 32: width of each instruction word.

Ports:
- `clk_clk`  in  1  system clock; the only clock.
- `reset_reset_n`  in  1  synchronous, active-low reset.
- `data_a`  in  DATA_W  instruction word A (opcode/register field), from PIO.
- `data_b`  in  DATA_W  instruction word B (data field), from PIO.
- `wrreg`  in  1  level strobe from PIO; each rising edge is one write request.
- `wrfull`  out  1  FIFO full; software polls it before toggling `wrreg`.
- `instr_a`  out  DATA_W  head-of-FIFO word A.
- `instr_b`  out  DATA_W  head-of-FIFO word B.
- `instr_valid`  out  1  head entry valid.
- `instr_ready`  in  1  decoder accepts the head entry.
- `drop_cnt`  out  16  saturating count of dropped writes; present only with `GPU_INSTR_DROP_CNT_EN`.

## Operation

- **Edge detect:** `wrreg_q` registers `wrreg`. A push request is `wrreg & ~wrreg_q`. A level held high produces exactly one request.
- **Push:** on a request, `{data_a, data_b}` is sampled in the same cycle and written at `wr_ptr`.
  - Accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
  - Otherwise the write is dropped and the FIFO is unchanged.
- **Pop:** `instr_valid & instr_ready`. Advances `rd_ptr`.
- **Show-ahead:** `instr_a`/`instr_b` always present `mem[rd_ptr]`. When `instr_valid` is 0, their values are don't-care.
- **Pointers:** `$clog2(DEPTH)` bits, wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits.
- **Count update:** push only: +1. Pop only: -1. Push and pop together: unchanged.
- **Flags:** `instr_valid = (count != 0)`, `wrfull = (count == DEPTH)`. Both are derived from the registered count.
- **No state machine:** the only states are the FIFO occupancy states EMPTY, PARTIAL and FULL, implied by `count`.

## Timing

- **Reset:** while `reset_reset_n` is low at a clock edge, `wr_ptr`, `rd_ptr`, `count`, `wrreg_q` and `drop_cnt` clear to 0.
  - Resulting outputs: `wrfull`=0, `instr_valid`=0.
  - FIFO memory is not cleared.
- **Reset mid-operation:** queued entries are discarded. If `wrreg` is high at reset release, `wrreg_q`=0 makes the first post-reset cycle a rising edge, and that write is pushed. Software must hold `wrreg` low during reset.
- **Latency:** `wrreg` rises and is sampled at edge N, so `instr_valid` is high from cycle N+1 when the FIFO was empty. Write-to-read latency is 1 cycle.
- **`wrfull` timing:**
  - Asserts in the cycle after the push that makes count = DEPTH.
  - Deasserts in the cycle after the first pop from full.
- **Handshake:**
  - The decoder may hold `instr_ready` high continuously, giving one pop per cycle.
  - The decoder may not rely on `instr_valid` deasserting without a pop.
  - `instr_a`/`instr_b` are stable while `instr_valid` is high and `instr_ready` is low.
- **Simultaneous push and pop on an empty FIFO:** there is no pop (`instr_valid`=0). The push is stored normally.

## Configuration

- **`GPU_INSTR_DROP_CNT_EN` defined:** the `drop_cnt` port exists.
  - It increments by 1 on every dropped push request.
  - It saturates at 16'hFFFF.
  - It clears only on reset.
- **Not defined:** the port, the counter and its logic are absent. Dropped writes are silently discarded.

## Structure

- **Package `gpu_instr_pkg`:**
  - constant `GPU_DATA_W` = 32;
  - typedef `gpu_instr_t` as a packed struct `{a, b}` of `GPU_DATA_W` each;
  - constant `GPU_FIFO_DEPTH` = 16.
- **Sub-module `gpu_instr_fifo`:** generic synchronous show-ahead FIFO (memory, pointers, count, full/empty).
- **Top level:** edge detect, the accept-when-full-with-pop rule, and the drop counter.

## Test plan

- **Reset check:** reset held 3 cycles → `wrfull`=0, `instr_valid`=0, `drop_cnt`=0.
- **Single write, single read:** `data_a`=32'h0000_0011, `data_b`=32'hCAFE_0001, `wrreg` 0→1 held 5 cycles, `instr_ready`=0.
  - `instr_valid`=1 one cycle after the edge, with `instr_a`/`instr_b` equal to the written values.
  - Exactly one entry is pushed.
  - Raise `instr_ready` → `instr_valid`=0 the next cycle.
- **Fill and overflow:** 16 toggled writes with `data_a`=i, then a 17th with `data_a`=32'hDEAD, `instr_ready`=0.
  - `wrfull`=1 after the 16th write.
  - The 17th write is dropped; `drop_cnt`=1 when the macro is defined.
  - Drain with `instr_ready`=1 → `instr_a` reads 0..15 in order; the DEAD value never appears.
- **Full with simultaneous push and pop:** FIFO full, `instr_ready`=1 in the same cycle as a `wrreg` edge with `data_a`=32'h99.
  - The push is accepted and `wrfull` stays 1.
  - After the drain, the last `instr_a` is 32'h99.
- **Wrap-around:** 40 writes interleaved with pops, occupancy kept between 1 and 15 → output order matches input order across pointer wrap, `wrfull` never asserts.
- **Reset mid-stream:** with 5 entries queued, pulse reset low for one edge → `instr_valid`=0 and `wrfull`=0 the next cycle. The next write becomes the head entry.
